aes_output_buffer: RTL

Serializes each 128-bit result from the AES core into four 32-bit words on a valid/ready stream. Word order matches the input-side loader: bits [31:0] first, [127:96] last. A one-entry pending register lets the core finish the next block while the current one drains. Sits between the core's `done`/result outputs and the 32-bit host read path.

---
 rtl/aes_buf_pkg.sv | 13 +
 rtl/aes_output_buffer.sv | 102 ++++++++++
 2 files changed

// File: rtl/aes_buf_pkg.sv
// Shared constants and state type for the AES input/output word buffers.
// Block width is always WORD_W * NUM_WORDS.
package aes_buf_pkg;

  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 4;
  localparam int BLK_W     = WORD_W * NUM_WORDS;
  localparam int IDX_W     = $clog2(NUM_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic {IDLE, SEND} obuf_state_t;

endpackage

// File: rtl/aes_output_buffer.sv
// Serializes 128-bit AES results into 32-bit valid/ready words, low word first,
// with a one-entry pending block so the core can finish the next result early.
//
// state | meaning
// IDLE  | no block in flight, out_valid low
// SEND  | active block draining, out_valid high
module aes_output_buffer
  import aes_buf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              done_i,
  input  logic [BLK_W-1:0]  text_i,
  output logic [WORD_W-1:0] text_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy_o,
  output logic              full_o,
  output logic              overrun_o,
  input  logic              clr_overrun_i
);

  obuf_state_t       state;
  logic [BLK_W-1:0]  active_q;
  logic [BLK_W-1:0]  pend_q;
  logic              pend_vld;
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] act_words [NUM_WORDS];
  logic              xfer;
  logic              last_xfer;

  always_comb begin
    for (int i = 0; i < NUM_WORDS; i++) begin
      act_words[i] = active_q[i*WORD_W +: WORD_W];
    end
  end

  assign xfer      = (state == SEND) && out_ready;
  assign last_xfer = xfer && (idx == LAST_IDX);

  // Outputs decode only state and registers, never inputs.
  assign out_valid = (state == SEND);
  assign text_out  = (state == SEND) ? act_words[idx] : '0;
  assign out_last  = (state == SEND) && (idx == LAST_IDX);
  assign busy_o    = (state == SEND) || pend_vld;
  assign full_o    = pend_vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      active_q  <= '0;
      pend_q    <= '0;
      pend_vld  <= 1'b0;
      idx       <= '0;
      overrun_o <= 1'b0;
    end else begin
      if (clr_overrun_i) begin
        overrun_o <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (done_i) begin
            active_q <= text_i;
            idx      <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            idx <= idx + 1'b1;
          end
          if (last_xfer) begin
            idx <= '0;
            if (pend_vld) begin
              active_q <= pend_q;
              if (done_i) begin
                pend_q <= text_i;
              end else begin
                pend_vld <= 1'b0;
              end
            end else if (done_i) begin
              active_q <= text_i;
            end else begin
              state <= IDLE;
            end
          end else if (done_i) begin
            // A second waiting block has nowhere to go; keep stored data intact.
            if (!pend_vld) begin
              pend_q   <= text_i;
              pend_vld <= 1'b1;
            end else begin
              overrun_o <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
